soda_dispense_arbiter: RTL and testbench

- Shares one physical soda dispenser mechanism among NUM_REQ vending-machine FSM instances.
- Each vending FSM pulses drop_req when it has collected enough credit.
- This block queues those requests per machine and grants the dispenser round-robin.
- It sequences a start/done handshake with the mechanism, enforces a cooldown gap between dispenses, and detects a stuck mechanism via timeout.

---
 rtl/soda_arb_pkg.sv | 44 ++++
 rtl/soda_pend_counter.sv | 51 +++++
 rtl/soda_dispense_arbiter.sv | 159 +++++++++++++++
 tb/tb_soda_dispense_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soda_arb_pkg.sv
// rtl/soda_arb_pkg.sv - shared types, defaults and round-robin helper for the soda dispense arbiter
// Contents: arb_state_t (arbiter FSM states), DEF_* parameter defaults,
// MAX_REQ (upper bound on requesters), rr_next() round-robin index search.
package soda_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    FAULT     = 3'd4
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_PEND_W         = 3;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int MAX_REQ            = 8;

  // Returns the first index with req set, scanning last+1, last+2, ... with
  // wrap at n. The scan runs from the farthest candidate back to the nearest
  // so the nearest hit overwrites the others. Returns last when nothing is set;
  // callers gate the result with an any-request flag.
  function automatic int rr_next(input logic [MAX_REQ-1:0] req,
                                 input int last,
                                 input int n);
    int res;
    int s;
    res = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        s = last + k;
        if (s >= n) begin
          s = s - n;
        end
        if (req[s[2:0]]) begin
          res = s;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/soda_pend_counter.sv
// rtl/soda_pend_counter.sv - saturating per-requester pending counter with sticky overflow
// Ports:
//   clock    in   clock, all updates on posedge
//   reset    in   synchronous active-high reset
//   inc      in   one request arrived this cycle
//   dec      in   one request granted this cycle
//   count    out  queued requests, saturates at 2^PEND_W-1
//   overflow out  sticky: a request arrived while full and was dropped
module soda_pend_counter
  import soda_arb_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count == CNT_MAX) begin
            overflow <= 1'b1;
          end else begin
            count <= count + PEND_W'(1);
          end
        end
        2'b01: begin
          // The arbiter only grants a nonzero counter; the guard keeps the
          // counter from wrapping if that ever changes.
          if (count != '0) begin
            count <= count - PEND_W'(1);
          end
        end
        default: begin
          // Idle, or arrival and grant cancel out.
        end
      endcase
    end
  end

endmodule

// File: rtl/soda_dispense_arbiter.sv
// rtl/soda_dispense_arbiter.sv - round-robin arbiter sharing one soda dispenser among vending FSMs
// Ports:
//   clock        in   clock, all updates on posedge
//   reset        in   synchronous active-high reset, aborts any dispense
//   drop_req     in   per-requester one-cycle vend pulse
//   motor_done   in   dispenser completion pulse, honoured only in WAIT_DONE
//   clear_fault  in   leaves FAULT
//   motor_start  out  one-cycle start pulse (high exactly during START)
//   grant_id     out  requester currently or last served
//   served       out  one-cycle pulse on the bit of the completed requester
//   busy         out  high in START / WAIT_DONE / GAP
//   fault        out  high in FAULT
//   overflow_err out  sticky per-requester lost-request flag
module soda_dispense_arbiter
  import soda_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int PEND_W         = DEF_PEND_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         drop_req,
  input  logic                       motor_done,
  input  logic                       clear_fault,
  output logic                       motor_start,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         served,
  output logic                       busy,
  output logic                       fault,
  output logic [NUM_REQ-1:0]         overflow_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // One timer serves both the done timeout and the post-dispense gap.
  localparam int T_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);

  arb_state_t                       state;
  logic [ID_W-1:0]                  last_grant;
  logic [TW-1:0]                    timer;

  logic [NUM_REQ-1:0][PEND_W-1:0]   pend_cnt;
  logic [NUM_REQ-1:0]               pend_nz;
  logic [MAX_REQ-1:0]               req_vec;
  int                               rr_idx;
  logic                             pick_valid;
  logic [ID_W-1:0]                  pick_id;
  logic [NUM_REQ-1:0]               grant_dec;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_pend
      soda_pend_counter #(
        .PEND_W (PEND_W)
      ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (drop_req[g]),
        .dec      (grant_dec[g]),
        .count    (pend_cnt[g]),
        .overflow (overflow_err[g])
      );
      assign pend_nz[g] = |pend_cnt[g];
    end
  endgenerate

  // Arbitration looks only at registered counts, so a request arriving this
  // cycle competes from the next cycle on.
  always_comb begin
    req_vec                = '0;
    req_vec[NUM_REQ-1:0]   = pend_nz;
    rr_idx                 = rr_next(req_vec, int'(last_grant), NUM_REQ);
    pick_valid             = (state == IDLE) && (|pend_nz);
    pick_id                = '0;
    grant_dec              = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == rr_idx) begin
        pick_id = ID_W'(i);
        if (pick_valid) begin
          grant_dec[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      timer       <= '0;
      motor_start <= 1'b0;
      served      <= '0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      motor_start <= 1'b0;
      served      <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id    <= pick_id;
            last_grant  <= pick_id;
            motor_start <= 1'b1;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          timer <= '0;
          busy  <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer <= timer + TW'(1);
          // Completion wins over a timeout landing in the same cycle.
          if (motor_done) begin
            served <= NUM_REQ'(1) << grant_id;
            timer  <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            // The stuck request is dropped, not re-queued.
            busy  <= 1'b0;
            fault <= 1'b1;
            state <= FAULT;
          end
        end
        GAP: begin
          if (timer == TW'(GAP_CYCLES - 1)) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        FAULT: begin
          if (clear_fault) begin
            fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          fault <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soda_dispense_arbiter.sv
// tb/tb_soda_dispense_arbiter.sv - self-checking bench for soda_dispense_arbiter
module tb_soda_dispense_arbiter;

  localparam int N   = 4;
  localparam int PW  = 3;
  localparam int TO  = 64;
  localparam int GC  = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] drop_req;
  logic         motor_done;
  logic         clear_fault;
  logic         motor_start;
  logic [1:0]   grant_id;
  logic [N-1:0] served;
  logic         busy;
  logic         fault;
  logic [N-1:0] overflow_err;

  always #5 clock = ~clock;

  soda_dispense_arbiter #(
    .NUM_REQ        (N),
    .PEND_W         (PW),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .drop_req     (drop_req),
    .motor_done   (motor_done),
    .clear_fault  (clear_fault),
    .motor_start  (motor_start),
    .grant_id     (grant_id),
    .served       (served),
    .busy         (busy),
    .fault        (fault),
    .overflow_err (overflow_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycle stepping with an optional automatic dispenser responder.
  int           cyc = 0;
  int           done_at = -1;
  bit           auto_resp = 0;
  int           resp_lo = 0;
  int           resp_hi = 0;
  logic [N-1:0] last_drop;
  logic         last_done;

  task automatic step();
    if (auto_resp) motor_done = (cyc == done_at);
    @(posedge clock);
    #1;
    last_drop = drop_req;
    last_done = motor_done;
    // Done arrives d+1 cycles after the start pulse cycle.
    if (auto_resp && motor_start) done_at = cyc + 2 + int'($urandom_range(resp_hi, resp_lo));
    cyc++;
    drop_req    = '0;
    motor_done  = 1'b0;
    clear_fault = 1'b0;
  endtask

  function automatic logic [31:0] pend_of(input int i);
    return 32'(dut.pend_cnt[i]);
  endfunction

  task automatic do_reset();
    reset = 1'b1; drop_req = '0; motor_done = 1'b0; clear_fault = 1'b0;
    done_at = -1;
    step();
    check("rst_motor_start", 32'(motor_start), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_served", 32'(served), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_overflow", 32'(overflow_err), 0);
    step();
    reset = 1'b0;
  endtask

  // Reference model: requests as integer queue depths plus round-robin pointer.
  int mp[N];
  bit mo[N];
  int mlast;
  int minflight;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mp[i] = 0; mo[i] = 0; end
    mlast = N - 1;
    minflight = 0;
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      if (mp[(mlast + k) % N] > 0) return (mlast + k) % N;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    int e;
    logic [N-1:0] ov;
    if (motor_start) begin
      e = model_pick();
      check("rnd_start_has_pending", 32'(e >= 0), 1);
      if (e >= 0) begin
        check("rnd_grant_id", 32'(grant_id), 32'(e));
        mp[e]--;
        mlast = e;
        minflight = e;
      end
    end
    check("rnd_served", 32'(served), last_done ? 32'(1 << minflight) : 0);
    for (int i = 0; i < N; i++) begin
      if (last_drop[i]) begin
        if (mp[i] == PMAX) mo[i] = 1;
        else mp[i]++;
      end
    end
    ov = '0;
    for (int i = 0; i < N; i++) ov[i] = mo[i];
    check("rnd_overflow", 32'(overflow_err), 32'(ov));
  endtask

  typedef struct {
    logic [N-1:0] drop;
    logic         done;
    logic         exp_ms;
    logic [1:0]   exp_gid;
    logic [N-1:0] exp_srv;
    logic         exp_busy;
    logic         exp_fault;
  } vec_t;

  vec_t vec[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q[$];
    int scnt[N];
    int start_cyc;
    int g2, g0;

    // Single request: latency, done 3 cycles after start, 4-cycle gap,
    // done ignored in GAP (row 7) and in IDLE (row 10).
    vec[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vec[1]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[2]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[3]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[4]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    vec[6]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[7]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[8]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vec[9]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vec[10] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};

    do_reset();
    auto_resp = 0;
    for (int r = 0; r < 11; r++) begin
      drop_req   = vec[r].drop;
      motor_done = vec[r].done;
      step();
      check($sformatf("vec%0d_motor_start", r), 32'(motor_start), 32'(vec[r].exp_ms));
      check($sformatf("vec%0d_grant_id", r), 32'(grant_id), 32'(vec[r].exp_gid));
      check($sformatf("vec%0d_served", r), 32'(served), 32'(vec[r].exp_srv));
      check($sformatf("vec%0d_busy", r), 32'(busy), 32'(vec[r].exp_busy));
      check($sformatf("vec%0d_fault", r), 32'(fault), 32'(vec[r].exp_fault));
    end

    // All four request together: round-robin order 0,1,2,3.
    do_reset();
    auto_resp = 1; resp_lo = 0; resp_hi = 0;
    for (int i = 0; i < N; i++) scnt[i] = 0;
    q = {};
    drop_req = 4'b1111;
    step();
    for (int k = 0; k < 60; k++) begin
      step();
      if (motor_start) q.push_back(int'(grant_id));
      for (int i = 0; i < N; i++) scnt[i] += int'(served[i]);
    end
    check("rr_grant_count", 32'(q.size()), 4);
    for (int k = 0; k < q.size() && k < 4; k++) check($sformatf("rr_order%0d", k), 32'(q[k]), 32'(k));
    for (int i = 0; i < N; i++) begin
      check($sformatf("rr_served%0d", i), 32'(scnt[i]), 1);
      check($sformatf("rr_pend%0d", i), pend_of(i), 0);
    end

    // Stalled dispenser: saturation, overflow, timeout to FAULT, recovery.
    do_reset();
    auto_resp = 0;
    start_cyc = -1;
    for (int p = 0; p < 9; p++) begin
      drop_req = 4'b0100;
      step();
      if (motor_start) start_cyc = cyc;
    end
    check("stall_started", 32'(start_cyc >= 0), 1);
    check("stall_pend2", pend_of(2), 32'(PMAX));
    check("stall_overflow", 32'(overflow_err), 32'(4'b0100));
    for (int k = 0; k < 120 && !fault; k++) step();
    check("stall_fault", 32'(fault), 1);
    check("stall_fault_latency", 32'(cyc - start_cyc), 32'(TO + 1));
    check("stall_busy_in_fault", 32'(busy), 0);
    drop_req = 4'b0001;
    step();
    check("fault_accumulate", pend_of(0), 1);
    check("fault_hold", 32'(fault), 1);
    clear_fault = 1'b1;
    step();
    check("fault_cleared", 32'(fault), 0);
    auto_resp = 1; resp_lo = 1; resp_hi = 1;
    g2 = 0; g0 = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (motor_start && grant_id == 2) g2++;
      if (motor_start && grant_id == 0) g0++;
    end
    check("recover_grants2", 32'(g2), 32'(PMAX));
    check("recover_grants0", 32'(g0), 1);
    check("recover_pend2", pend_of(2), 0);
    check("overflow_sticky", 32'(overflow_err), 32'(4'b0100));

    // Request arriving in the same cycle its counter is granted.
    do_reset();
    auto_resp = 0;
    drop_req = 4'b0010;
    step();
    drop_req = 4'b0010;
    step();
    check("same_cycle_start", 32'(motor_start), 1);
    check("same_cycle_gid", 32'(grant_id), 1);
    check("same_cycle_pend1", pend_of(1), 1);
    check("same_cycle_ovf", 32'(overflow_err), 0);

    // Reset during WAIT_DONE discards the in-flight request.
    do_reset();
    auto_resp = 0;
    drop_req = 4'b0001;
    step();
    step();
    check("abort_started", 32'(motor_start), 1);
    drop_req = 4'b1000;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_motor_start", 32'(motor_start), 0);
    check("abort_fault", 32'(fault), 0);
    check("abort_served", 32'(served), 0);
    for (int i = 0; i < N; i++) check($sformatf("abort_pend%0d", i), pend_of(i), 0);
    motor_done = 1'b1;
    step();
    check("abort_late_done", 32'(served), 0);
    step();
    check("abort_idle_start", 32'(motor_start), 0);
    check("abort_idle_busy", 32'(busy), 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    auto_resp = 1; resp_lo = 0; resp_hi = 6;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k < 800) drop_req[i] = ($urandom_range(3, 0) == 0);
        else         drop_req[i] = ($urandom_range(31, 0) == 0);
      end
      step();
      model_cycle();
    end
    for (int k = 0; k < 700; k++) begin
      step();
      model_cycle();
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("rnd_final_pend%0d", i), pend_of(i), 32'(mp[i]));
      check($sformatf("rnd_model_drained%0d", i), 32'(mp[i]), 0);
    end
    check("rnd_final_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
